// File: rtl/even_operand_fetch_if.sv
`default_nettype none
// ============================================================================
// Module   : even_operand_fetch_if
// Purpose  : Decoded-instruction intake and issued-instruction bus of the
//            even-pipe operand fetch stage.
// Revision : 1.0
// ============================================================================
interface even_operand_fetch_if;
  logic         in_valid;
  logic         in_ready;
  logic [10:0]  in_op;
  logic [2:0]   in_format;
  logic [1:0]   in_unit;
  logic [6:0]   in_rt_addr;
  logic         in_reg_write;
  logic [17:0]  in_imm;
  logic [6:0]   in_ra_addr, in_rb_addr, in_rc_addr;
  logic         in_ra_used, in_rb_used, in_rc_used;
  logic [127:0] rf_ra, rf_rb, rf_rc;

  logic         out_valid;
  logic [10:0]  out_op;
  logic [2:0]   out_format;
  logic [1:0]   out_unit;
  logic [6:0]   out_rt_addr;
  logic         out_reg_write;
  logic [17:0]  out_imm;
  logic [127:0] out_ra, out_rb, out_rc;

  modport master (
    output in_valid, in_op, in_format, in_unit, in_rt_addr, in_reg_write, in_imm,
           in_ra_addr, in_rb_addr, in_rc_addr, in_ra_used, in_rb_used, in_rc_used,
           rf_ra, rf_rb, rf_rc,
    input  in_ready, out_valid, out_op, out_format, out_unit, out_rt_addr,
           out_reg_write, out_imm, out_ra, out_rb, out_rc
  );

  modport slave (
    input  in_valid, in_op, in_format, in_unit, in_rt_addr, in_reg_write, in_imm,
           in_ra_addr, in_rb_addr, in_rc_addr, in_ra_used, in_rb_used, in_rc_used,
           rf_ra, rf_rb, rf_rc,
    output in_ready, out_valid, out_op, out_format, out_unit, out_rt_addr,
           out_reg_write, out_imm, out_ra, out_rb, out_rc
  );
endinterface
`default_nettype wire

// File: rtl/even_operand_fetch.sv
`default_nettype none
// ============================================================================
// Module   : even_operand_fetch
// Purpose  : Holds one decoded instruction, stalls on RAW hazards, resolves
//            operands by forwarding and issues to the even pipe.
// Revision : 1.0
// ============================================================================
module even_operand_fetch #(
  parameter int NPEND   = 16,
  parameter int STALL_W = 16
) (
  input  logic                      clk,
  input  logic                      reset,
  even_operand_fetch_if.slave       bus,
  input  logic [6:0][127:0]         fw_wb,
  input  logic [6:0][6:0]           fw_addr_wb,
  input  logic [6:0]                fw_write_wb,
  input  logic [127:0]              rt_wb,
  input  logic [6:0]                rt_addr_wb,
  input  logic                      reg_write_wb,
  input  logic [NPEND-1:0][6:0]     pend_addr,
  input  logic [NPEND-1:0]          pend_write,
  input  logic                      branch_taken,
  output logic                      hazard,
  output logic [STALL_W-1:0]        stall_count
);

  typedef enum logic [0:0] {EMPTY = 1'b0, HOLD = 1'b1} state_t;

  typedef struct packed {
    logic [10:0] op;
    logic [2:0]  format;
    logic [1:0]  unit;
    logic [6:0]  rt_addr;
    logic        reg_write;
    logic [17:0] imm;
  } ctrl_t;

  state_t             state, state_next;
  ctrl_t              r_ctrl, r_out_ctrl, w_in_ctrl;
  logic [2:0][6:0]    r_src_addr, w_in_addr;
  logic [2:0]         r_src_used, w_in_used;
  logic [2:0][127:0]  r_src_data, w_in_data, w_operand, r_out_opnd;
  logic [2:0]         w_src_hit;
  logic               w_held, w_hazard, w_issue, w_accept, w_ready;
  logic               r_out_valid;
  logic [STALL_W-1:0] r_stall;
  logic               unused_fw0;

  // Slot 0 of the forwarding buses carries no usable stage.
  assign unused_fw0 = ^{fw_wb[0], fw_addr_wb[0], fw_write_wb[0]};

  assign w_in_ctrl = '{op: bus.in_op, format: bus.in_format, unit: bus.in_unit,
                       rt_addr: bus.in_rt_addr, reg_write: bus.in_reg_write,
                       imm: bus.in_imm};
  assign w_in_addr = {bus.in_rc_addr, bus.in_rb_addr, bus.in_ra_addr};
  assign w_in_used = {bus.in_rc_used, bus.in_rb_used, bus.in_ra_used};
  assign w_in_data = {bus.rf_rc, bus.rf_rb, bus.rf_ra};

  // Per used source: pending-destination match, and operand selection where
  // the youngest forwarding stage overrides write-back, which overrides RF.
  always_comb begin
    w_src_hit = '0;
    w_operand = r_src_data;
    for (int s = 0; s < 3; s++) begin
      if (r_src_used[s]) begin
        for (int i = 0; i < NPEND; i++) begin
          if (pend_write[i] && pend_addr[i] == r_src_addr[s]) w_src_hit[s] = 1'b1;
        end
        if (reg_write_wb && rt_addr_wb == r_src_addr[s]) w_operand[s] = rt_wb;
        for (int k = 6; k >= 1; k--) begin
          if (fw_write_wb[k] && fw_addr_wb[k] == r_src_addr[s]) w_operand[s] = fw_wb[k];
        end
      end
    end
  end

  assign w_held   = (state == HOLD);
  assign w_hazard = w_held && (|w_src_hit);
  assign w_issue  = w_held && !w_hazard && !branch_taken;
  assign w_ready  = !w_held || w_issue;
  assign w_accept = bus.in_valid && w_ready && !branch_taken;

  always_ff @(posedge clk) begin
    if (reset) state <= EMPTY;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      EMPTY: if (w_accept) state_next = HOLD;
      HOLD: begin
        if (branch_taken)              state_next = EMPTY;
        else if (w_issue && !w_accept) state_next = EMPTY;
      end
      default: state_next = EMPTY;
    endcase
  end

  // Hold register; while waiting, retiring write-backs refresh stale RF reads.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_ctrl     <= '0;
      r_src_addr <= '0;
      r_src_used <= '0;
      r_src_data <= '0;
    end else if (w_accept) begin
      r_ctrl     <= w_in_ctrl;
      r_src_addr <= w_in_addr;
      r_src_used <= w_in_used;
      r_src_data <= w_in_data;
    end else if (w_held) begin
      for (int s = 0; s < 3; s++) begin
        if (r_src_used[s] && reg_write_wb && rt_addr_wb == r_src_addr[s])
          r_src_data[s] <= rt_wb;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_out_valid <= 1'b0;
      r_out_ctrl  <= '0;
      r_out_opnd  <= '0;
    end else begin
      r_out_valid <= w_issue;
      if (w_issue) begin
        r_out_ctrl <= r_ctrl;
        r_out_opnd <= w_operand;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) r_stall <= '0;
    else if (w_hazard && !branch_taken && r_stall != {STALL_W{1'b1}})
      r_stall <= r_stall + 1'b1;
  end

  assign bus.in_ready      = w_ready;
  assign bus.out_valid     = r_out_valid;
  assign bus.out_op        = r_out_ctrl.op;
  assign bus.out_format    = r_out_ctrl.format;
  assign bus.out_unit      = r_out_ctrl.unit;
  assign bus.out_rt_addr   = r_out_ctrl.rt_addr;
  assign bus.out_reg_write = r_out_ctrl.reg_write;
  assign bus.out_imm       = r_out_ctrl.imm;
  assign bus.out_ra        = r_out_opnd[0];
  assign bus.out_rb        = r_out_opnd[1];
  assign bus.out_rc        = r_out_opnd[2];
  assign hazard            = w_hazard;
  assign stall_count       = r_stall;

endmodule
`default_nettype wire

// File: tb/tb_even_operand_fetch.sv
`default_nettype none
// ============================================================================
// Module   : tb_even_operand_fetch
// Purpose  : Directed scenarios plus randomized traffic against a
//            behavioural model of the even operand fetch stage.
// Revision : 1.0
// ============================================================================
module tb_even_operand_fetch;
  localparam int NPEND = 16;

  typedef struct packed {
    logic [10:0] op;
    logic [2:0]  format;
    logic [1:0]  unit;
    logic [6:0]  rt;
    logic        rw;
    logic [17:0] imm;
  } ctrl_t;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  even_operand_fetch_if bus();
  even_operand_fetch_if bus2();

  logic [6:0][127:0]     fw_wb;
  logic [6:0][6:0]       fw_addr_wb;
  logic [6:0]            fw_write_wb;
  logic [127:0]          rt_wb;
  logic [6:0]            rt_addr_wb;
  logic                  reg_write_wb;
  logic [NPEND-1:0][6:0] pend_addr;
  logic [NPEND-1:0]      pend_write;
  logic                  branch_taken;
  logic                  hazard, hazard2;
  logic [15:0]           stall_count;
  logic [1:0]            stall_count2;

  int errors = 0;
  int checks = 0;

  assign bus2.in_valid     = bus.in_valid;
  assign bus2.in_op        = bus.in_op;
  assign bus2.in_format    = bus.in_format;
  assign bus2.in_unit      = bus.in_unit;
  assign bus2.in_rt_addr   = bus.in_rt_addr;
  assign bus2.in_reg_write = bus.in_reg_write;
  assign bus2.in_imm       = bus.in_imm;
  assign bus2.in_ra_addr   = bus.in_ra_addr;
  assign bus2.in_rb_addr   = bus.in_rb_addr;
  assign bus2.in_rc_addr   = bus.in_rc_addr;
  assign bus2.in_ra_used   = bus.in_ra_used;
  assign bus2.in_rb_used   = bus.in_rb_used;
  assign bus2.in_rc_used   = bus.in_rc_used;
  assign bus2.rf_ra        = bus.rf_ra;
  assign bus2.rf_rb        = bus.rf_rb;
  assign bus2.rf_rc        = bus.rf_rc;

  even_operand_fetch #(.NPEND(NPEND), .STALL_W(16)) dut (
    .clk(clk), .reset(reset), .bus(bus.slave),
    .fw_wb(fw_wb), .fw_addr_wb(fw_addr_wb), .fw_write_wb(fw_write_wb),
    .rt_wb(rt_wb), .rt_addr_wb(rt_addr_wb), .reg_write_wb(reg_write_wb),
    .pend_addr(pend_addr), .pend_write(pend_write), .branch_taken(branch_taken),
    .hazard(hazard), .stall_count(stall_count)
  );

  // Narrow counter instance shares all stimulus, to observe saturation.
  even_operand_fetch #(.NPEND(NPEND), .STALL_W(2)) dut2 (
    .clk(clk), .reset(reset), .bus(bus2.slave),
    .fw_wb(fw_wb), .fw_addr_wb(fw_addr_wb), .fw_write_wb(fw_write_wb),
    .rt_wb(rt_wb), .rt_addr_wb(rt_addr_wb), .reg_write_wb(reg_write_wb),
    .pend_addr(pend_addr), .pend_write(pend_write), .branch_taken(branch_taken),
    .hazard(hazard2), .stall_count(stall_count2)
  );

  // ---------------- stimulus helpers ----------------
  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs;
    bus.in_valid = 1'b0; bus.in_op = '0; bus.in_format = '0; bus.in_unit = '0;
    bus.in_rt_addr = '0; bus.in_reg_write = 1'b0; bus.in_imm = '0;
    bus.in_ra_addr = '0; bus.in_rb_addr = '0; bus.in_rc_addr = '0;
    bus.in_ra_used = 1'b0; bus.in_rb_used = 1'b0; bus.in_rc_used = 1'b0;
    bus.rf_ra = '0; bus.rf_rb = '0; bus.rf_rc = '0;
    fw_wb = '0; fw_addr_wb = '0; fw_write_wb = '0;
    rt_wb = '0; rt_addr_wb = '0; reg_write_wb = 1'b0;
    pend_addr = '0; pend_write = '0; branch_taken = 1'b0;
  endtask

  task automatic do_reset;
    idle_inputs();
    reset = 1'b1;
    tick(); tick();
    reset = 1'b0;
  endtask

  task automatic present(input logic [6:0] rt, input logic [6:0] ra, input logic [6:0] rb,
                         input logic [6:0] rc, input logic [2:0] used,
                         input logic [127:0] da, input logic [127:0] db, input logic [127:0] dc);
    bus.in_valid = 1'b1; bus.in_op = {4'h0, rt}; bus.in_format = 3'd1; bus.in_unit = 2'd3;
    bus.in_rt_addr = rt; bus.in_reg_write = 1'b1; bus.in_imm = {11'h0, rt};
    bus.in_ra_addr = ra; bus.in_rb_addr = rb; bus.in_rc_addr = rc;
    bus.in_ra_used = used[0]; bus.in_rb_used = used[1]; bus.in_rc_used = used[2];
    bus.rf_ra = da; bus.rf_rb = db; bus.rf_rc = dc;
  endtask

  function automatic logic [127:0] rnd128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  // ---------------- directed scenarios ----------------
  task automatic test_reset;
    do_reset();
    checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b expected 0", bus.out_valid); end
    checks++; if ({bus.out_op, bus.out_rt_addr, bus.out_imm, bus.out_ra} !== '0) begin errors++; $display("FAIL reset_out_fields: got nonzero expected 0"); end
    checks++; if (stall_count !== 16'd0) begin errors++; $display("FAIL reset_stall: got %0d expected 0", stall_count); end
    checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready: got %b expected 1", bus.in_ready); end
    checks++; if (hazard !== 1'b0) begin errors++; $display("FAIL reset_hazard: got %b expected 0", hazard); end
  endtask

  task automatic test_basic;
    do_reset();
    present(7'd5, 7'd3, 7'd4, 7'd0, 3'b011, {16{8'h11}}, {16{8'h22}}, '0);
    #1;
    checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL basic_ready: got %b expected 1", bus.in_ready); end
    tick();
    checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL basic_early: got %b expected 0", bus.out_valid); end
    bus.in_valid = 1'b0; bus.rf_ra = '1; bus.rf_rb = '1;
    #1;
    checks++; if ({hazard, bus.in_ready} !== 2'b01) begin errors++; $display("FAIL basic_hold_comb: got %b expected 01", {hazard, bus.in_ready}); end
    tick();
    checks++; if (bus.out_valid !== 1'b1) begin errors++; $display("FAIL basic_valid: got %b expected 1", bus.out_valid); end
    checks++; if (bus.out_ra !== {16{8'h11}}) begin errors++; $display("FAIL basic_ra: got %h expected %h", bus.out_ra, {16{8'h11}}); end
    checks++; if (bus.out_rb !== {16{8'h22}}) begin errors++; $display("FAIL basic_rb: got %h expected %h", bus.out_rb, {16{8'h22}}); end
    checks++; if ({bus.out_op, bus.out_rt_addr, bus.out_unit} !== {11'h005, 7'd5, 2'd3}) begin errors++; $display("FAIL basic_fields: got %h/%0d/%0d expected 005/5/3", bus.out_op, bus.out_rt_addr, bus.out_unit); end
    checks++; if (stall_count !== 16'd0) begin errors++; $display("FAIL basic_stall: got %0d expected 0", stall_count); end
    tick();
    checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL basic_pulse: got %b expected 0", bus.out_valid); end
  endtask

  task automatic test_forward_priority;
    logic [127:0] a, b, c, d, exp;
    a = {4{32'hAAAA_0001}}; b = {4{32'hBBBB_0006}}; c = {4{32'hCCCC_00FB}}; d = {4{32'hDDDD_0101}};
    do_reset();
    for (int n = 0; n < 3; n++) begin
      idle_inputs();
      present(7'd1, 7'd7, 7'd0, 7'd0, 3'b001, {4{32'h0F0F_0F0F}}, '0, '0);
      tick();
      bus.in_valid = 1'b0;
      fw_addr_wb[1] = 7'd8; fw_wb[1] = d; fw_write_wb[1] = 1'b1;
      fw_addr_wb[2] = 7'd7; fw_wb[2] = a; fw_write_wb[2] = (n == 0);
      fw_addr_wb[6] = 7'd7; fw_wb[6] = b; fw_write_wb[6] = (n < 2);
      rt_addr_wb = 7'd7; rt_wb = c; reg_write_wb = 1'b1;
      tick();
      exp = (n == 0) ? a : (n == 1) ? b : c;
      checks++; if ({bus.out_valid, bus.out_ra} !== {1'b1, exp}) begin errors++; $display("FAIL fwd_prio_%0d: got %b/%h expected 1/%h", n, bus.out_valid, bus.out_ra, exp); end
    end
  endtask

  task automatic test_stall_snoop;
    do_reset();
    present(7'd2, 7'd0, 7'd9, 7'd0, 3'b010, '0, {4{32'h3333_3333}}, '0);
    tick();
    bus.in_valid = 1'b0;
    pend_addr[3] = 7'd9; pend_write[3] = 1'b1;
    rt_wb = {4{32'hDEAD_BEEF}}; rt_addr_wb = 7'd9; reg_write_wb = 1'b1;
    for (int n = 0; n < 3; n++) begin
      #1;
      checks++; if ({hazard, bus.in_ready} !== 2'b10) begin errors++; $display("FAIL stall_comb_%0d: got %b expected 10", n, {hazard, bus.in_ready}); end
      tick();
      checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL stall_no_issue_%0d: got %b expected 0", n, bus.out_valid); end
      reg_write_wb = 1'b0; rt_wb = '0;
    end
    checks++; if (stall_count !== 16'd3) begin errors++; $display("FAIL stall_count: got %0d expected 3", stall_count); end
    pend_write = '0;
    #1;
    checks++; if (hazard !== 1'b0) begin errors++; $display("FAIL stall_release: got %b expected 0", hazard); end
    tick();
    checks++; if ({bus.out_valid, bus.out_rb} !== {1'b1, {4{32'hDEAD_BEEF}}}) begin errors++; $display("FAIL snoop_rb: got %b/%h expected 1/%h", bus.out_valid, bus.out_rb, {4{32'hDEAD_BEEF}}); end
    checks++; if (stall_count !== 16'd3) begin errors++; $display("FAIL stall_count_hold: got %0d expected 3", stall_count); end
  endtask

  task automatic test_flush;
    do_reset();
    present(7'd10, 7'd1, 7'd0, 7'd0, 3'b001, {4{32'h1010_1010}}, '0, '0);
    tick();
    present(7'd11, 7'd1, 7'd0, 7'd0, 3'b001, {4{32'h1111_1111}}, '0, '0);
    branch_taken = 1'b1;
    #1;
    checks++; if (bus.in_ready !== 1'b0) begin errors++; $display("FAIL flush_ready: got %b expected 0", bus.in_ready); end
    tick();
    checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL flush_no_issue: got %b expected 0", bus.out_valid); end
    idle_inputs();
    #1;
    checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL flush_empty: got %b expected 1", bus.in_ready); end
    tick();
    checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL flush_dropped: got %b expected 0", bus.out_valid); end
    present(7'd12, 7'd1, 7'd0, 7'd0, 3'b001, '0, '0, '0);
    branch_taken = 1'b1;
    tick();
    idle_inputs();
    tick();
    checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL flush_empty_drop: got %b expected 0", bus.out_valid); end
  endtask

  task automatic test_reset_mid_hold;
    do_reset();
    present(7'd13, 7'd2, 7'd0, 7'd0, 3'b001, {4{32'h1313_1313}}, '0, '0);
    tick();
    bus.in_valid = 1'b0;
    tick();
    present(7'd14, 7'd2, 7'd0, 7'd0, 3'b001, {4{32'h1414_1414}}, '0, '0);
    tick();
    bus.in_valid = 1'b0;
    pend_addr[0] = 7'd2; pend_write[0] = 1'b1;
    #1;
    checks++; if (hazard !== 1'b1) begin errors++; $display("FAIL rst_hold_hazard: got %b expected 1", hazard); end
    tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    #1;
    checks++; if ({bus.out_valid, bus.out_rt_addr, bus.out_ra} !== '0) begin errors++; $display("FAIL rst_hold_out: got %b/%0d/%h expected zero", bus.out_valid, bus.out_rt_addr, bus.out_ra); end
    checks++; if (stall_count !== 16'd0) begin errors++; $display("FAIL rst_hold_stall: got %0d expected 0", stall_count); end
    checks++; if ({bus.in_ready, hazard} !== 2'b10) begin errors++; $display("FAIL rst_hold_comb: got %b expected 10", {bus.in_ready, hazard}); end
    tick();
    checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL rst_hold_discard: got %b expected 0", bus.out_valid); end
  endtask

  task automatic test_saturation;
    do_reset();
    present(7'd3, 7'd20, 7'd0, 7'd0, 3'b001, '0, '0, '0);
    tick();
    bus.in_valid = 1'b0;
    pend_addr[5] = 7'd20; pend_write[5] = 1'b1;
    repeat (6) tick();
    checks++; if (stall_count !== 16'd6) begin errors++; $display("FAIL sat_wide: got %0d expected 6", stall_count); end
    checks++; if (stall_count2 !== 2'd3) begin errors++; $display("FAIL sat_narrow: got %0d expected 3", stall_count2); end
    pend_write = '0;
    tick();
    checks++; if ({bus.out_valid, stall_count2} !== {1'b1, 2'd3}) begin errors++; $display("FAIL sat_issue: got %b/%0d expected 1/3", bus.out_valid, stall_count2); end
  endtask

  task automatic test_back_to_back;
    do_reset();
    for (int n = 0; n < 8; n++) begin
      present(7'(n + 32), 7'(n + 40), 7'd0, 7'd0, 3'b001, {4{32'(n * 3 + 1)}}, '0, '0);
      #1;
      checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL b2b_ready_%0d: got %b expected 1", n, bus.in_ready); end
      tick();
      if (n > 0) begin
        checks++;
        if ({bus.out_valid, bus.out_rt_addr, bus.out_ra} !== {1'b1, 7'(n + 31), {4{32'((n - 1) * 3 + 1)}}}) begin
          errors++; $display("FAIL b2b_issue_%0d: got %b/%0d/%h", n, bus.out_valid, bus.out_rt_addr, bus.out_ra);
        end
      end
    end
  endtask

  // ---------------- randomized traffic vs behavioural model ----------------
  logic         m_held;
  ctrl_t        m_ctrl, e_ctrl;
  logic [6:0]   m_addr [3];
  logic         m_used [3];
  logic [127:0] m_data [3];
  logic [127:0] e_opnd [3];
  logic         e_valid;
  int           e_sc, e_sc2;

  // Most recent stage holding the register wins; else write-back; else RF.
  function automatic logic [127:0] resolve(input logic [6:0] a, input logic used, input logic [127:0] rf);
    if (!used) return rf;
    for (int k = 1; k <= 6; k++)
      if (fw_write_wb[k] && fw_addr_wb[k] == a) return fw_wb[k];
    if (reg_write_wb && rt_addr_wb == a) return rt_wb;
    return rf;
  endfunction

  task automatic test_random;
    logic haz, issue, ready, accept;
    logic [127:0] res [3];
    do_reset();
    m_held = 1'b0; e_valid = 1'b0; e_ctrl = '0; e_sc = 0; e_sc2 = 0;
    for (int s = 0; s < 3; s++) e_opnd[s] = '0;
    for (int n = 0; n < 3000; n++) begin
      reset = ($urandom_range(0, 199) == 0);
      bus.in_valid = ($urandom_range(0, 3) != 0);
      bus.in_op = 11'($urandom); bus.in_format = 3'($urandom); bus.in_unit = 2'($urandom);
      bus.in_rt_addr = 7'($urandom); bus.in_reg_write = 1'($urandom); bus.in_imm = 18'($urandom);
      bus.in_ra_addr = 7'($urandom_range(0, 7)); bus.in_rb_addr = 7'($urandom_range(0, 7));
      bus.in_rc_addr = 7'($urandom_range(0, 7));
      bus.in_ra_used = 1'($urandom); bus.in_rb_used = 1'($urandom); bus.in_rc_used = 1'($urandom);
      bus.rf_ra = rnd128(); bus.rf_rb = rnd128(); bus.rf_rc = rnd128();
      for (int k = 0; k < 7; k++) begin
        fw_addr_wb[k] = 7'($urandom_range(0, 7)); fw_write_wb[k] = ($urandom_range(0, 2) == 0); fw_wb[k] = rnd128();
      end
      rt_addr_wb = 7'($urandom_range(0, 7)); reg_write_wb = 1'($urandom); rt_wb = rnd128();
      for (int i = 0; i < NPEND; i++) begin
        pend_addr[i] = 7'($urandom_range(0, 7)); pend_write[i] = ($urandom_range(0, 15) == 0);
      end
      branch_taken = ($urandom_range(0, 15) == 0);

      haz = 1'b0;
      for (int s = 0; s < 3; s++)
        for (int i = 0; i < NPEND; i++)
          if (m_held && m_used[s] && pend_write[i] && pend_addr[i] == m_addr[s]) haz = 1'b1;
      issue  = m_held && !haz && !branch_taken;
      ready  = !m_held || issue;
      accept = bus.in_valid && ready && !branch_taken;
      for (int s = 0; s < 3; s++) res[s] = resolve(m_addr[s], m_used[s], m_data[s]);

      #1;
      checks++; if ({hazard, bus.in_ready} !== {haz, ready}) begin errors++; $display("FAIL rnd_comb_%0d: got %b expected %b", n, {hazard, bus.in_ready}, {haz, ready}); end
      tick();

      if (reset) begin
        m_held = 1'b0; e_valid = 1'b0; e_ctrl = '0; e_sc = 0; e_sc2 = 0;
        for (int s = 0; s < 3; s++) e_opnd[s] = '0;
      end else begin
        if (m_held && haz && !branch_taken) begin
          if (e_sc < 65535) e_sc++;
          if (e_sc2 < 3) e_sc2++;
        end
        e_valid = issue;
        if (issue) begin
          e_ctrl = m_ctrl;
          for (int s = 0; s < 3; s++) e_opnd[s] = res[s];
        end
        if (accept) begin
          m_held = 1'b1;
          m_ctrl = '{op: bus.in_op, format: bus.in_format, unit: bus.in_unit,
                     rt: bus.in_rt_addr, rw: bus.in_reg_write, imm: bus.in_imm};
          m_addr[0] = bus.in_ra_addr; m_addr[1] = bus.in_rb_addr; m_addr[2] = bus.in_rc_addr;
          m_used[0] = bus.in_ra_used; m_used[1] = bus.in_rb_used; m_used[2] = bus.in_rc_used;
          m_data[0] = bus.rf_ra; m_data[1] = bus.rf_rb; m_data[2] = bus.rf_rc;
        end else if (branch_taken || issue) begin
          m_held = 1'b0;
        end else if (m_held) begin
          for (int s = 0; s < 3; s++)
            if (m_used[s] && reg_write_wb && rt_addr_wb == m_addr[s]) m_data[s] = rt_wb;
        end
      end

      checks++; if (bus.out_valid !== e_valid) begin errors++; $display("FAIL rnd_valid_%0d: got %b expected %b", n, bus.out_valid, e_valid); end
      checks++;
      if ({bus.out_op, bus.out_format, bus.out_unit, bus.out_rt_addr, bus.out_reg_write, bus.out_imm} !== e_ctrl) begin
        errors++; $display("FAIL rnd_ctrl_%0d: got %h expected %h", n,
          {bus.out_op, bus.out_format, bus.out_unit, bus.out_rt_addr, bus.out_reg_write, bus.out_imm}, e_ctrl);
      end
      checks++;
      if ({bus.out_ra, bus.out_rb, bus.out_rc} !== {e_opnd[0], e_opnd[1], e_opnd[2]}) begin
        errors++; $display("FAIL rnd_opnd_%0d: got %h %h %h expected %h %h %h", n,
          bus.out_ra, bus.out_rb, bus.out_rc, e_opnd[0], e_opnd[1], e_opnd[2]);
      end
      checks++;
      if ({stall_count, stall_count2} !== {16'(e_sc), 2'(e_sc2)}) begin
        errors++; $display("FAIL rnd_stall_%0d: got %0d/%0d expected %0d/%0d", n, stall_count, stall_count2, e_sc, e_sc2);
      end
    end
    reset = 1'b0;
  endtask

  initial begin
    reset = 1'b1;
    idle_inputs();
    test_reset();
    test_basic();
    test_forward_priority();
    test_stall_snoop();
    test_flush();
    test_reset_mid_hold();
    test_saturation();
    test_back_to_back();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
`default_nettype wire

// File: doc/even_operand_fetch.md
Name: even_operand_fetch

Overview:
- Register-fetch/forward stage that feeds the even pipeline.
- Accepts one decoded instruction at a time and detects RAW hazards against in-flight destinations that cannot yet be forwarded.
- Stalls the instruction until its sources are available, then resolves each operand from the forwarding stages, the write-back stage or the register file.
- Issues a registered, operand-complete instruction to the even pipe; it consumes the fw_wb/fw_addr_wb/fw_write_wb and rt_wb buses the pipe produces.

Parameters:
NPEND, 16, number of in-flight destination entries presented on pend_addr/pend_write
STALL_W, 16, width of the saturating stall counter

Ports:
clk  in  1  clock
reset  in  1  synchronous active-high reset
in_valid  in  1  decoded instruction present
in_ready  out  1  stage can accept an instruction this cycle
in_op  in  11  decoded opcode
in_format  in  3  instruction format
in_unit  in  2  execution unit (0 FP, 1 FX2, 2 Byte, 3 FX1)
in_rt_addr  in  7  destination register
in_reg_write  in  1  instruction writes the register file
in_imm  in  18  immediate
in_ra_addr, in_rb_addr, in_rc_addr  in  7 each  source register addresses
in_ra_used, in_rb_used, in_rc_used  in  1 each  source is actually read
rf_ra, rf_rb, rf_rc  in  128 each  register-file read data, valid in the accept cycle only
fw_wb  in  7x128  forwarding stage values, index 1 youngest, 6 oldest; index 0 ignored
fw_addr_wb  in  7x7  forwarding stage destinations
fw_write_wb  in  7  forwarding stage write enables
rt_wb  in  128  write-back value
rt_addr_wb  in  7  write-back destination
reg_write_wb  in  1  write-back enable
pend_addr  in  NPENDx7  in-flight destinations not yet forwardable
pend_write  in  NPEND  entry valid
branch_taken  in  1  flush
out_valid  out  1  issued instruction valid (one-cycle pulse per instruction)
out_op, out_format, out_unit, out_rt_addr, out_reg_write, out_imm  out  11/3/2/7/1/18  issued fields
out_ra, out_rb, out_rc  out  128 each  resolved operands
hazard  out  1  held instruction is stalled this cycle
stall_count  out  STALL_W  saturating count of stall cycles

Behaviour:
- Reset (synchronous): held_valid=0, out_valid=0, all out_* fields=0, stall_count=0. in_ready=1 and hazard=0 in the first cycle after reset.
- States are EMPTY (held_valid=0) and HOLD (held_valid=1). The output register is loaded independently of the state.
- in_ready = !held_valid || issue, where issue = held_valid && !hazard && !branch_taken.
- Accept (in_valid && in_ready && !branch_taken): at the edge, latch all in_* fields and rf_ra/rf_rb/rf_rc into the hold register; go to HOLD.
- Hazard (combinational on held sources): for any used source S, hazard=1 if some i has pend_write[i] && pend_addr[i]==S_addr. Register 0 is not special.
- Operand resolution for a used source, first match wins:
  - fw_wb[1..6] with fw_write_wb[k] and matching address, lowest k first;
  - then rt_wb if reg_write_wb and rt_addr_wb matches;
  - then the latched RF value.
- An unused source passes the latched RF value.
- WB snoop: every cycle in HOLD, if reg_write_wb and rt_addr_wb matches a held source, overwrite that latched RF value with rt_wb. This covers values retired during a stall.
- Issue: at the edge where issue=1, load the out_* fields with the held fields and resolved operands, and set out_valid=1.
  - Held_valid follows acceptance: if a new instruction is accepted in the same cycle, stay in HOLD with the new instruction; otherwise go to EMPTY.
  - Otherwise out_valid=0; out_* fields hold their last values.
- Minimum latency: accept at edge k, out_valid high after edge k+1. Back-to-back issue without hazards gives one instruction per cycle.
- Stall counter: stall_count increments at each edge with held_valid && hazard && !branch_taken, saturating at 2^STALL_W-1. Only reset clears it.
- Flush: branch_taken at an edge forces held_valid=0 and out_valid=0; any in_valid that cycle is dropped. in_ready remains as computed.
- Reset asserted mid-HOLD discards the held instruction; it has priority over every other event.

Test Plan:
- Reset then accept add rt=5 ra=3 rb=4, no pend/fw matches, rf_ra=0x11.., rf_rb=0x22.. -> out_valid one cycle after accept with out_ra=0x11.., out_rb=0x22..; stall_count=0.
- Held ra=7 with fw_addr_wb[2]=7 value A and fw_addr_wb[6]=7 value B, both write=1, plus rt_addr_wb=7 value C -> out_ra=A. Drop fw[2] -> B; drop fw[6] too -> C.
- pend_addr[3]=9 valid for 3 cycles, held rb=9 -> hazard=1 and in_ready=0 for 3 cycles, stall_count=3, issue the following cycle.
- During the stall above, rt_wb=0xDEAD.. addr 9 pulses once and then goes away with no fw match -> out_rb=0xDEAD..
- Flush mid-HOLD with in_valid=1 -> no out_valid next cycle and the new instruction is dropped. Reset mid-HOLD -> all outputs 0 and in_ready=1.
- STALL_W=2, hazard held for 6 cycles -> stall_count saturates at 3.
